// File: rtl/mul_i8_o8_err_mon.sv
// Response-side error monitor for the 4x4 approximate multiplier: accepts (pi, po)
// pairs, computes |po - a*b| and accumulates run statistics over N_SAMPLES pairs.
module mul_i8_o8_err_mon #(
    parameter int N_SAMPLES = 100,
    parameter int CNT_W     = 16,
    parameter int SUM_W     = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       pi,
    input  logic [7:0]       po,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [7:0]       max_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state;
    logic              xfer, last, start_ok;
    logic [7:0]        exact, abs_err;
    logic signed [8:0] diff;
    logic              s1_vld, s1_neq;
    logic [7:0]        s1_abs;
    logic [SUM_W:0]    sum_next;

    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    assign xfer     = in_valid && in_ready;
    assign last     = (sample_cnt == CNT_W'(N_SAMPLES - 1));
    assign start_ok = start && ((state == IDLE) || (state == DONE));

    // 9-bit signed difference covers -225..255; magnitude always fits in 8 bits
    assign exact   = {4'b0, pi[3:0]} * {4'b0, pi[7:4]};
    assign diff    = $signed({1'b0, po}) - $signed({1'b0, exact});
    assign abs_err = diff[8] ? 8'(-diff) : diff[7:0];

    assign sum_next = {1'b0, sum_abs_err} + (SUM_W+1)'(s1_abs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= RUN;
                RUN:     if (xfer && last) state <= DRAIN;
                DRAIN:   state <= DONE;
                DONE:    if (start) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_abs <= '0;
            s1_neq <= 1'b0;
        end else begin
            s1_vld <= xfer;
            if (xfer) begin
                s1_abs <= abs_err;
                s1_neq <= (po != exact);
            end
        end
    end

    // Stage 2: accumulate the registered error; start only fires when no pair is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
        end else if (start_ok) begin
            sample_cnt  <= '0;
            err_cnt     <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
        end else begin
            if (xfer)
                sample_cnt <= sample_cnt + 1'b1;
            if (s1_vld) begin
                err_cnt     <= err_cnt + CNT_W'(s1_neq);
                sum_abs_err <= sum_next[SUM_W] ? '1 : sum_next[SUM_W-1:0];
                if (s1_abs > max_err)
                    max_err <= s1_abs;
            end
        end
    end

endmodule

// File: tb/tb_mul_i8_o8_err_mon.sv
// Randomized scoreboard bench for mul_i8_o8_err_mon: three instances (N=4, N=3, and a
// narrow saturating accumulator with N=2) share clock and reset.
module tb_mul_i8_o8_err_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic        vld_v   [3];
    logic [7:0]  pi_v    [3];
    logic [7:0]  po_v    [3];
    logic        rdy     [3];
    logic        bsy     [3];
    logic        dn      [3];
    logic [15:0] scnt    [3];
    logic [15:0] ecnt    [3];
    logic [7:0]  mx      [3];
    logic [23:0] sum0, sum1;
    logic [7:0]  sum2;

    typedef struct {
        int inst;
        int cnt;
        int errs;
        int sum;
        int mx;
    } model_t;

    model_t      sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  pt [8];
    logic [7:0]  ot [8];

    always #5 clk = ~clk;

    mul_i8_o8_err_mon #(.N_SAMPLES(4), .CNT_W(16), .SUM_W(24)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(vld_v[0]), .in_ready(rdy[0]),
        .pi(pi_v[0]), .po(po_v[0]), .busy(bsy[0]), .done(dn[0]), .sample_cnt(scnt[0]),
        .err_cnt(ecnt[0]), .sum_abs_err(sum0), .max_err(mx[0]));

    mul_i8_o8_err_mon #(.N_SAMPLES(3), .CNT_W(16), .SUM_W(24)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(vld_v[1]), .in_ready(rdy[1]),
        .pi(pi_v[1]), .po(po_v[1]), .busy(bsy[1]), .done(dn[1]), .sample_cnt(scnt[1]),
        .err_cnt(ecnt[1]), .sum_abs_err(sum1), .max_err(mx[1]));

    mul_i8_o8_err_mon #(.N_SAMPLES(2), .CNT_W(16), .SUM_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(vld_v[2]), .in_ready(rdy[2]),
        .pi(pi_v[2]), .po(po_v[2]), .busy(bsy[2]), .done(dn[2]), .sample_cnt(scnt[2]),
        .err_cnt(ecnt[2]), .sum_abs_err(sum2), .max_err(mx[2]));

    function automatic int sum_of(input int i);
        case (i)
            0:       return int'(sum0);
            1:       return int'(sum1);
            default: return int'(sum2);
        endcase
    endfunction

    function automatic int n_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 3 : 2;
    endfunction

    function automatic int abs_err_ref(input logic [7:0] p, input logic [7:0] o);
        int e;
        e = int'(o) - int'(p[3:0]) * int'(p[7:4]);
        return (e < 0) ? -e : e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: on each rising done, pop the expected statistics and compare
    initial begin
        logic done_q [3];
        model_t m;
        for (int i = 0; i < 3; i++) done_q[i] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (dn[i] && !done_q[i]) begin
                    n_checks++;
                    if (sb_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_empty: done rose on inst %0d with no expected run", i);
                    end else begin
                        m = sb_q.pop_front();
                        chk("sb_inst", i, m.inst);
                        chk("sb_sample_cnt", int'(scnt[i]), m.cnt);
                        chk("sb_err_cnt", int'(ecnt[i]), m.errs);
                        chk("sb_sum_abs_err", sum_of(i), m.sum);
                        chk("sb_max_err", int'(mx[i]), m.mx);
                    end
                end
                done_q[i] = dn[i];
            end
        end
    end

    // One run on instance inst using pt/ot; gap_mask bit k inserts an idle cycle before pair k
    task automatic run(input int inst, input int gap_mask, input bit extra, input bit abort2);
        model_t m;
        int n, lim, e;
        n   = n_of(inst);
        lim = (inst == 2) ? 255 : (1 << 24) - 1;
        m   = '{inst, n, 0, 0, 0};
        @(negedge clk);
        start_v[inst] = 1'b1;
        vld_v[inst]   = 1'b1;       // offered alongside start: must not be accepted
        pi_v[inst]    = 8'($urandom);
        po_v[inst]    = 8'($urandom);
        @(negedge clk);
        start_v[inst] = 1'b0;
        vld_v[inst]   = 1'b0;
        chk("busy_after_start", int'(bsy[inst]), 1);
        chk("done_after_start", int'(dn[inst]), 0);
        chk("cnt_cleared", int'(scnt[inst]), 0);
        chk("sum_cleared", sum_of(inst), 0);
        chk("max_cleared", int'(mx[inst]), 0);
        chk("err_cleared", int'(ecnt[inst]), 0);
        for (int k = 0; k < n; k++) begin
            if (gap_mask[k]) begin
                vld_v[inst] = 1'b0;
                @(negedge clk);
            end
            chk("ready_in_run", int'(rdy[inst]), 1);
            vld_v[inst] = 1'b1;
            pi_v[inst]  = pt[k];
            po_v[inst]  = ot[k];
            e = abs_err_ref(pt[k], ot[k]);
            m.errs += (e != 0) ? 1 : 0;
            m.sum   = (m.sum + e > lim) ? lim : m.sum + e;
            m.mx    = (e > m.mx) ? e : m.mx;
            @(negedge clk);
            vld_v[inst] = 1'b0;
            if (abort2 && k == 1) begin
                #2 rst = 1'b1;
                #1;
                for (int i = 0; i < 3; i++) begin
                    chk("rst_ready", int'(rdy[i]), 0);
                    chk("rst_busy", int'(bsy[i]), 0);
                    chk("rst_done", int'(dn[i]), 0);
                end
                chk("rst_cnt", int'(scnt[inst]), 0);
                chk("rst_sum", sum_of(inst), 0);
                chk("rst_max", int'(mx[inst]), 0);
                chk("rst_errs", int'(ecnt[inst]), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        sb_q.push_back(m);
        chk("drain_ready", int'(rdy[inst]), 0);
        chk("drain_busy", int'(bsy[inst]), 1);
        chk("drain_done", int'(dn[inst]), 0);
        if (extra) begin
            vld_v[inst] = 1'b1;
            pi_v[inst]  = 8'($urandom);
            po_v[inst]  = 8'($urandom);
        end
        @(negedge clk);
        chk("done_latency", int'(dn[inst]), 1);
        chk("done_busy", int'(bsy[inst]), 0);
        if (extra) begin
            @(negedge clk);
            vld_v[inst] = 1'b0;
            chk("extra_not_counted", int'(scnt[inst]), n);
        end
        @(negedge clk);
    endtask

    task automatic rand_tab();
        int x;
        for (int k = 0; k < 8; k++) begin
            pt[k] = 8'($urandom);
            x = int'(pt[k][3:0]) * int'(pt[k][7:4]);
            case ($urandom_range(0, 2))
                0:       ot[k] = 8'(x);
                1:       ot[k] = 8'((x + int'($urandom_range(0, 6)) - 3 < 0) ? 0 : x + int'($urandom_range(0, 6)) - 3);
                default: ot[k] = 8'($urandom);
            endcase
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            vld_v[i]   = 1'b0;
            pi_v[i]    = '0;
            po_v[i]    = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset_ready", int'(rdy[i]), 0);
            chk("reset_busy", int'(bsy[i]), 0);
            chk("reset_done", int'(dn[i]), 0);
            chk("reset_cnt", int'(scnt[i]), 0);
            chk("reset_max", int'(mx[i]), 0);
        end
        chk("reset_sum0", sum_of(0), 0);
        @(negedge clk);
        rst = 1'b0;

        // exact run, back-to-back
        pt[0] = 8'hA3; ot[0] = 8'd30;
        pt[1] = 8'hD7; ot[1] = 8'd91;
        pt[2] = 8'h45; ot[2] = 8'd20;
        pt[3] = 8'hEC; ot[3] = 8'd168;
        run(0, 0, 1'b0, 1'b0);

        // restart from DONE with the worst-case error
        pt[0] = 8'hFF; ot[0] = 8'd0;
        run(0, 0, 1'b1, 1'b0);

        // approximate errors with valid pattern 1,0,1,1 and a post-run valid pulse
        pt[0] = 8'hA3; ot[0] = 8'd28;
        pt[1] = 8'h69; ot[1] = 8'd64;
        pt[2] = 8'h03; ot[2] = 8'd0;
        run(1, 3'b010, 1'b1, 1'b0);

        // saturation of an 8-bit accumulator: 200 + 200 -> 255
        pt[0] = 8'h00; ot[0] = 8'd200;
        pt[1] = 8'h00; ot[1] = 8'd200;
        run(2, 0, 1'b0, 1'b0);

        // reset after 2 of 4 transfers, then a full run
        rand_tab();
        run(0, 0, 1'b0, 1'b1);
        rand_tab();
        run(0, int'($urandom_range(0, 15)), 1'b0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            rand_tab();
            run(r % 3, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
